// File: rtl/seg_pkg.sv
// rtl/seg_pkg.sv - shared constants for the seven-segment scan driver
package seg_pkg;
  localparam logic [3:0] BLANK_CODE         = 4'hF;
  localparam int         DEFAULT_NUM_DIGITS = 4;
endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - free-running prescaler producing one tick per digit slot
module scan_tick_gen #(
  parameter int CLK_DIV = 50000,
  localparam int CW     = $clog2(CLK_DIV)
) (
  input  logic          clk,
  input  logic          rst,
  output logic          tick,
  output logic [CW-1:0] count
);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;

  always_comb begin
    tick    = (count_q == CW'(CLK_DIV - 1));
    count_d = tick ? '0 : count_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed BCD display scanner with frame-aligned
// double-buffered loads, leading-zero blanking and dead time between digits
module seven_seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS = DEFAULT_NUM_DIGITS,
  parameter int CLK_DIV    = 50000,
  parameter int DEAD_CYC   = 2,
  localparam int CW        = $clog2(CLK_DIV),
  localparam int IDX_W     = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] digits_in,
  input  logic                    blank_lz,
  output logic [3:0]              digit_nibble,
  output logic [NUM_DIGITS-1:0]   digit_en,
  output logic                    frame_done
);

  logic          tick;
  logic [CW-1:0] count;

  scan_tick_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst   (rst),
    .tick  (tick),
    .count (count)
  );

  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [4*NUM_DIGITS-1:0] active_q, active_d;
  logic [4*NUM_DIGITS-1:0] pending_q, pending_d;
  logic                    pending_valid_q, pending_valid_d;
  logic [NUM_DIGITS-1:0]   digit_en_q, digit_en_d;
  logic [3:0]              digit_nibble_q, digit_nibble_d;
  logic                    frame_done_q, frame_done_d;

  logic                    boundary;
  logic [NUM_DIGITS-1:0]   lz;
  logic                    zero_run;
  logic [3:0]              cur_nib;
  logic                    cur_lz;
  logic [NUM_DIGITS-1:0]   onehot;

  always_comb begin
    boundary = tick && (idx_q == IDX_W'(NUM_DIGITS - 1));

    idx_d = idx_q;
    if (tick) begin
      idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + 1'b1;
    end

    // Boundary copy reads the old pending, so a coinciding load lands a frame later.
    active_d        = active_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;
    if (boundary && pending_valid_q) begin
      active_d        = pending_q;
      pending_valid_d = 1'b0;
    end
    if (load) begin
      pending_d       = digits_in;
      pending_valid_d = 1'b1;
    end
  end

  always_comb begin
    lz       = '0;
    zero_run = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run = zero_run & (active_q[i*4 +: 4] == 4'h0);
      lz[i]    = zero_run;
    end

    cur_nib = 4'h0;
    cur_lz  = 1'b0;
    onehot  = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (idx_q == IDX_W'(i)) begin
        cur_nib   = active_q[i*4 +: 4];
        cur_lz    = lz[i];
        onehot[i] = 1'b1;
      end
    end

    digit_nibble_d = (blank_lz && cur_lz) ? BLANK_CODE : cur_nib;
    digit_en_d     = (count >= CW'(DEAD_CYC)) ? onehot : '0;
    frame_done_d   = boundary;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q           <= '0;
      active_q        <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      digit_en_q      <= '0;
      digit_nibble_q  <= BLANK_CODE;
      frame_done_q    <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      active_q        <= active_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      digit_en_q      <= digit_en_d;
      digit_nibble_q  <= digit_nibble_d;
      frame_done_q    <= frame_done_d;
    end
  end

  assign digit_en     = digit_en_q;
  assign digit_nibble = digit_nibble_q;
  assign frame_done   = frame_done_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - frame-table and scoreboard bench for seven_seg_scan_driver
module tb_seven_seg_scan_driver;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        load = 1'b0;
  logic [15:0] digits_in = 16'h0;
  logic        blank_lz = 1'b0;
  logic [3:0]  digit_nibble;
  logic [3:0]  digit_en;
  logic        frame_done;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] en;
    logic [3:0] nib;
    logic       fd;
  } exp_t;

  typedef struct {
    int          load_a_off;
    logic [15:0] load_a_data;
    int          load_b_off;
    logic [15:0] load_b_data;
    logic        blank;
    logic [15:0] exp_nibs;
  } frame_vec_t;

  exp_t       sb_q[$];
  frame_vec_t vecs[11];

  seven_seg_scan_driver #(
    .NUM_DIGITS (4),
    .CLK_DIV    (4),
    .DEAD_CYC   (1)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .load         (load),
    .digits_in    (digits_in),
    .blank_lz     (blank_lz),
    .digit_nibble (digit_nibble),
    .digit_en     (digit_en),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", name, act, exp);
    end
  endtask

  function automatic exp_t frame_exp(input int o, input logic [15:0] nibs);
    exp_t e;
    int   slot;
    slot  = o / 4;
    e.en  = ((o % 4) >= 1) ? 4'(1 << slot) : 4'h0;
    e.nib = nibs[slot*4 +: 4];
    e.fd  = (o == 15);
    return e;
  endfunction

  // Called at a negedge: drives inputs for the next edge, then checks that edge's outputs.
  task automatic drive_cycle(input string tag, input logic ld, input logic [15:0] d,
                             input logic bl, input exp_t e);
    exp_t got;
    load      = ld;
    digits_in = d;
    blank_lz  = bl;
    sb_q.push_back(e);
    @(negedge clk);
    if (sb_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL %s scoreboard_empty got 0 expected 1", tag);
    end else begin
      got = sb_q.pop_front();
      check({tag, " en"},  16'(digit_en),     16'(got.en));
      check({tag, " nib"}, 16'(digit_nibble), 16'(got.nib));
      check({tag, " fd"},  16'(frame_done),   16'(got.fd));
    end
  endtask

  task automatic run_frame(input int fr, input frame_vec_t v, input int last_off);
    logic        ld;
    logic [15:0] d;
    for (int o = 0; o <= last_off; o++) begin
      ld = 1'b0;
      d  = 16'h0;
      if (o == v.load_a_off) begin ld = 1'b1; d = v.load_a_data; end
      if (o == v.load_b_off) begin ld = 1'b1; d = v.load_b_data; end
      drive_cycle($sformatf("f%0d o%0d", fr, o), ld, d, v.blank, frame_exp(o, v.exp_nibs));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, " en"},  16'(digit_en),     16'h0);
    check({tag, " nib"}, 16'(digit_nibble), 16'hF);
    check({tag, " fd"},  16'(frame_done),   16'h0);
  endtask

  initial begin
    frame_vec_t v;
    // {load_a_off, data, load_b_off, data, blank, expected nibbles digit3..digit0}
    vecs[0]  = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000};
    vecs[1]  = '{ 6, 16'h1234, -1, 16'h0000, 1'b0, 16'h0000};
    vecs[2]  = '{ 3, 16'h0070, -1, 16'h0000, 1'b0, 16'h1234};
    vecs[3]  = '{ 2, 16'h0000, -1, 16'h0000, 1'b1, 16'hFF70};
    vecs[4]  = '{ 1, 16'h0A0C, -1, 16'h0000, 1'b1, 16'hFFF0};
    vecs[5]  = '{-1, 16'h0000, -1, 16'h0000, 1'b1, 16'hFA0C};
    vecs[6]  = '{ 2, 16'h1111,  9, 16'h2222, 1'b0, 16'h0A0C};
    vecs[7]  = '{ 5, 16'h1234, 15, 16'h5555, 1'b0, 16'h2222};
    vecs[8]  = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h1234};
    vecs[9]  = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h5555};
    vecs[10] = '{ 4, 16'h9876, -1, 16'h0000, 1'b0, 16'h5555};

    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("reset");
    rst = 1'b0;

    for (int f = 0; f < 11; f++) begin
      run_frame(f, vecs[f], 15);
    end

    // Reset lands in the digit-2 slot while 4321 is pending.
    v = '{0, 16'h4321, -1, 16'h0000, 1'b0, 16'h9876};
    run_frame(11, v, 9);
    load = 1'b0;
    rst  = 1'b1;
    #1;
    check_reset_outputs("rst_async");
    repeat (2) @(negedge clk);
    check_reset_outputs("rst_held");
    rst = 1'b0;

    v = '{-1, 16'h0000, -1, 16'h0000, 1'b0, 16'h0000};
    run_frame(12, v, 15);
    run_frame(13, v, 15);

    if (sb_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_leftover got %0d expected 0", sb_q.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1);
  end

endmodule

// File: doc/seven_seg_scan_driver.md
SEVEN_SEG_SCAN_DRIVER -- requirements
Module: seven_seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 4: number of multiplexed digits.
REQ-002 SHALL have parameter CLK_DIV, default 50000: clock cycles per digit slot; legal values are 2 or more.
REQ-003 SHALL have parameter DEAD_CYC, default 2: cycles at the start of each slot during which all digits are off; legal values are 0 to CLK_DIV-1.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-006 SHALL have port load, input, 1 bit: a one-cycle strobe that captures digits_in.
REQ-007 SHALL have port digits_in, input, 4*NUM_DIGITS bits: BCD digits, with digit 0 (least significant) in bits [3:0].
REQ-008 SHALL have port blank_lz, input, 1 bit: enables leading-zero blanking; sampled every cycle.
REQ-009 SHALL have port digit_nibble, output, 4 bits: code for the 7-segment decoder input.
REQ-010 SHALL have port digit_en, output, NUM_DIGITS bits: one-hot active-high digit select.
REQ-011 SHALL have port frame_done, output, 1 bit: one-cycle pulse when a full scan frame completes.

Function
REQ-012 SHALL hold a prescaler that counts 0..CLK_DIV-1 and wraps; tick is asserted when the prescaler equals CLK_DIV-1.
REQ-013 SHALL hold a digit index that counts 0..NUM_DIGITS-1, advances on each tick and wraps from NUM_DIGITS-1 to 0.
REQ-014 SHALL treat a tick with index NUM_DIGITS-1 as the frame boundary.
REQ-015 SHALL, on load, write digits_in into a pending register and set pending_valid.
REQ-016 SHALL let a later load before the next boundary overwrite pending, so only the last value is ever displayed.
REQ-017 SHALL, at a frame boundary with pending_valid=1, copy pending into the active register and clear pending_valid.
REQ-018 SHALL, when load coincides with a frame boundary, copy the old pending (if valid) into active and write the new data to pending with pending_valid=1.
REQ-019 SHALL mark a digit as a leading zero when it is 0 and all more-significant active digits are 0; digit 0 is never blanked.
REQ-020 SHALL output 4'hF on digit_nibble for a leading zero when blank_lz=1, otherwise active[index].
REQ-021 SHALL pass active nibbles above 9 through unchanged.
REQ-022 SHALL drive digit_en = one-hot(index) when prescaler >= DEAD_CYC, else all zero.
REQ-023 SHALL register all outputs, giving one cycle of latency from the prescaler/index state to digit_en, digit_nibble and frame_done.
REQ-024 SHALL pulse frame_done high for exactly one cycle following each frame boundary.

Reset
REQ-025 SHALL, while rst=1 and independent of clk, set the prescaler to 0, the index to 0, active to 0, pending to 0 and pending_valid to 0.
REQ-026 SHALL, while rst=1, drive digit_en=0, digit_nibble=4'hF and frame_done=0.
REQ-027 SHALL discard any pending load on reset mid-frame and restart the scan from digit 0, prescaler 0, after rst is released.

Structure
REQ-028 SHALL take BLANK_CODE (4'hF) and the NUM_DIGITS default from a shared package, seg_pkg.
REQ-029 SHALL implement the prescaler and tick as one sub-module, scan_tick_gen (parameter CLK_DIV; outputs tick and count).
REQ-030 SHALL keep the leading-zero mask, the load/pending logic and the output registers in the top module.

Verification
All scenarios use CLK_DIV=4, DEAD_CYC=1, NUM_DIGITS=4.
REQ-031 SHALL check: reset, then blank_lz=0 -> digit_nibble 0 on every digit; digit_en is 0 for 1 cycle then the one-hot select for 3 cycles per slot, in the sequence 0001,0010,0100,1000; frame_done pulses every 16 cycles.
REQ-032 SHALL check: load 16'h1234 mid-frame -> the current frame is unchanged; the next frame shows nibbles 4,3,2,1 on digits 0..3.
REQ-033 SHALL check: blank_lz=1 with 16'h0070 -> digits 3..0 show F,F,7,0; with 16'h0000 -> digits 3..0 show F,F,F,0.
REQ-034 SHALL check: load 16'h1111 then 16'h2222 within one frame -> 2222 is displayed and 1111 never appears.
REQ-035 SHALL check: load 16'h5555 on the boundary cycle while 16'h1234 is pending -> the next frame shows 1234 and the frame after shows 5555.
REQ-036 SHALL check: rst asserted during the digit-2 slot -> digit_en=0 and digit_nibble=F immediately; after release the scan restarts at digit 0 with the pending load lost.
